demux_deserializer: RTL
=======================

# demux_deserializer

Serial-to-parallel receiver that rebuilds an 8-bit word from a bit stream, one bit per qualified cycle. It is the 1-to-8 counterpart of the 8:1 selection path: a 3-bit bit index steers each incoming bit into its slot of the word. A completed word is presented on a valid/ready output port. It sits at the receive end of the narrow serial links in the mux/demux datapath family.

## Interface
- `LSB_FIRST`, default 1: 1 means the first bit of a frame lands in `dout[0]`; 0 means it lands in `dout[7]`.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `din` input, 1 bit: serial data bit.
- `din_valid` input, 1 bit: `din` is sampled on this cycle.
- `start` input, 1 bit: frame marker. It is meaningful only when `din_valid`=1, and marks that bit as bit 0 of a new frame.
- `dout` output, 8 bits: assembled word.
- `dout_valid` output, 1 bit: `dout` holds an unconsumed word.
- `dout_ready` input, 1 bit: consumer accepts the word when `dout_valid`=1.
- `sel` output, 3 bits: index of the next bit to be written (0..7).
- `busy` output, 1 bit: a frame is in progress (state SHIFT).
- `overrun` output, 1 bit: sticky; a completed word was dropped.
- `frame_err` output, 1 bit: sticky; a frame was aborted by an early `start`.

## Operation
- **States:**
  - IDLE: no frame in progress.
  - SHIFT: collecting bits 1..7.
- **Reset** (`rst_n`=0 at a rising edge): state IDLE, shift register 0, `sel`=0, `dout`=8'h00, `dout_valid`=0, `busy`=0, `overrun`=0, `frame_err`=0.
  - Reset mid-frame or with a word pending discards everything; there is no partial output.
- **Bit mapping:** bit index k is written to `dout[k]` when `LSB_FIRST`=1, and to `dout[7-k]` when `LSB_FIRST`=0. Unwritten slots of the internal register are don't-care; all 8 are written before transfer.
- **IDLE:**
  - `din_valid`=1 and `start`=1: write bit 0, set `sel`=1, go to SHIFT.
  - `din_valid`=1 and `start`=0: the bit is ignored.
  - `din_valid`=0: stay in IDLE.
- **SHIFT:**
  - `din_valid`=0: hold all state (gaps of any length are allowed).
  - `din_valid`=1 and `start`=0: write bit `sel`, then `sel`+1.
    - When the written bit is index 7, the word is complete: `sel` wraps to 0 and the state returns to IDLE.
  - `din_valid`=1 and `start`=1: resynchronise. Set `frame_err`=1, discard the partial word, write this bit as bit 0, set `sel`=1, stay in SHIFT.
- **Word transfer** (on completion):
  - If `dout_valid`=0, or `dout_ready`=1 on the same cycle: load `dout` and set `dout_valid`=1.
  - Otherwise: keep the old `dout`, drop the new word, set `overrun`=1.
- **Output handshake:**
  - `dout_valid`=1 with `dout_ready`=1 consumes the word; `dout_valid` clears next cycle unless a new word loads on that same cycle.
  - `dout` is stable while `dout_valid`=1 and not consumed.
- **Sticky flags:** `overrun` and `frame_err` clear only on reset.

## Timing
- `sel`, `busy` and state update on the rising edge at which the bit is sampled.
- Latency: `dout`/`dout_valid` are registered and update on the same edge that samples bit 7. They are visible from the cycle after the 8th valid bit is presented, giving a minimum of 8 cycles from the start bit to `dout_valid`.
- Back-to-back frames:
  - A `start` bit may arrive on the cycle immediately after bit 7 (state is IDLE by then). No dead cycle is required.
  - Throughput is one word per 8 valid cycles.
- Simultaneous completion and consumption (`dout_ready`=1 on the completing edge): the old word is consumed, the new word loads, `dout_valid` stays 1, and no overrun is flagged.
- `dout_ready` while `dout_valid`=0 has no effect.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with random inputs -> all outputs 0, `sel`=0.
- **LSB_FIRST=1 frame:** `start` with bits 0,1,0,1,0,1,0,1 on 8 consecutive cycles, `dout_ready`=1 -> `dout`=8'hAA, `dout_valid` high for exactly 1 cycle. `sel` steps 1..7 and then 0.
- **LSB_FIRST=0 frame:** same stream -> `dout`=8'h55. Then insert 3-cycle `din_valid` gaps after bits 2 and 5 -> same result, delayed 6 cycles.
- **Overrun:** two back-to-back frames 8'hAA then 8'h0F with `dout_ready`=0 -> `dout` stays 8'hAA and `overrun`=1. Then `dout_ready`=1 for one cycle -> `dout_valid`=0 and `overrun` stays 1.
- **Resync:** `start` and 3 bits, then a second `start` followed by 7 more bits encoding 8'hC3 -> `frame_err`=1, `dout`=8'hC3, and only one `dout_valid` event.
- **Reset mid-frame and simultaneous consume:** `rst_n`=0 after bit 4 -> no word is produced and `sel`=0. Then complete a frame while an older word is pending and `dout_ready`=1 on the completion edge -> the new word is shown, `dout_valid` stays 1, `overrun`=0.

Source files
------------

// File: rtl/demux_deserializer_if.sv
// Bundle of the serial input, parallel valid/ready output and status signals of demux_deserializer.
// The master side feeds bits and consumes words. The slave side is the deserializer itself.
interface demux_deserializer_if;
  logic       din;
  logic       din_valid;
  logic       start;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] sel;
  logic       busy;
  logic       overrun;
  logic       frame_err;

  modport master (
    output din, din_valid, start, dout_ready,
    input  dout, dout_valid, sel, busy, overrun, frame_err
  );

  modport slave (
    input  din, din_valid, start, dout_ready,
    output dout, dout_valid, sel, busy, overrun, frame_err
  );
endinterface

// File: rtl/demux_deserializer.sv
// Serial-to-parallel receiver: steers each qualified bit into its slot of an 8-bit word
// selected by a 3-bit index, then offers the finished word on a valid/ready port.
module demux_deserializer #(
  parameter int LSB_FIRST = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  demux_deserializer_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       complete;

  // Bit index k maps to slot k for LSB-first frames and to slot 7-k otherwise.
  function automatic logic [2:0] slot(input logic [2:0] k);
    return (LSB_FIRST != 0) ? k : 3'(3'd7 - k);
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    shreg_d      = shreg_q;
    sel_d        = sel_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = frame_err_q;
    complete     = 1'b0;

    if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.din_valid && bus.start) begin
          shreg_d[slot(3'd0)] = bus.din;
          sel_d               = 3'd1;
          state_d             = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.din_valid) begin
          if (bus.start) begin
            // An early start abandons the partial word and restarts at bit 0.
            frame_err_d         = 1'b1;
            shreg_d             = '0;
            shreg_d[slot(3'd0)] = bus.din;
            sel_d               = 3'd1;
          end else begin
            shreg_d[slot(sel_q)] = bus.din;
            sel_d                = 3'(sel_q + 3'd1);
            if (sel_q == 3'd7) begin
              complete = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished word loads only into an empty or simultaneously drained output slot.
    if (complete) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = shreg_d;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      sel_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sel_q        <= sel_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sel        = sel_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;

endmodule
